rom_burst_arbiter: RTL
======================

Name: rom_burst_arbiter

Overview:
- Shares one synchronous single-port ROM (1-cycle registered read latency) between N requesters.
- Each requester posts a start address and a burst length. The block grants requesters round-robin, sequences consecutive ROM addresses for the burst, and routes the returned words back tagged per requester.
- Sits between the ROM instance and the client engines (table lookups, microcode fetch).

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, ROM word width.
- ADDR_WIDTH, 8, ROM address width.
- LEN_WIDTH, 4, burst length field width; burst beats = len + 1.

Ports:
- clk_i  input  1  clock, all logic on rising edge.
- arstn_i  input  1  reset, asynchronous assert, active-low.
- req_valid_i  input  N_REQ  per-requester request valid.
- req_ready_o  output  N_REQ  per-requester accept; one-hot or zero.
- req_addr_i  input  N_REQ*ADDR_WIDTH  packed start addresses; requester k at [k*ADDR_WIDTH +: ADDR_WIDTH].
- req_len_i  input  N_REQ*LEN_WIDTH  packed burst lengths (beats-1).
- rom_addr_o  output  ADDR_WIDTH  address to ROM.
- rom_data_i  input  DATA_WIDTH  ROM registered read data.
- rsp_valid_o  output  N_REQ  one-hot response valid.
- rsp_data_o  output  DATA_WIDTH  response word, equal to rom_data_i.
- rsp_last_o  output  1  final beat of burst, qualified by any rsp_valid_o.
- busy_o  output  1  high when not in IDLE or a response is pending.

Behaviour:
- Reset (arstn_i low, asynchronous):
  - state=IDLE, rr pointer=0.
  - req_ready_o=0, rsp_valid_o=0, rsp_last_o=0, rom_addr_o=0, busy_o=0, beat counter=0.
- A reset asserted mid-burst aborts the burst immediately; the in-flight response is dropped and no valid is emitted.
- Handshake: a request transfers when req_valid_i[k] and req_ready_o[k] are both high in the same cycle.
  - req_ready_o is asserted combinationally only in IDLE, for the chosen requester.
  - Requesters hold valid, addr and len stable until accepted.
- Arbitration (IDLE, any valid):
  - Scan from rr pointer upward, modulo N_REQ; first valid wins.
  - On accept, rr pointer = winner+1 (mod N_REQ).
  - Latch owner, addr and len; go to BURST.
- BURST:
  - Each cycle drive rom_addr_o = cur_addr and issue one beat.
  - cur_addr increments modulo 2^ADDR_WIDTH; 0xFF wraps to 0x00 for ADDR_WIDTH=8.
  - The beat counter counts up to len. After issuing beat len, go to IDLE.
- Response pipeline, one stage matching ROM latency:
  - issue-valid, owner and last flag registered.
  - rsp_valid_o[owner] and rsp_last_o are asserted the cycle after the address is issued.
- Timing: request accepted at cycle T.
  - First address at T+1, first rsp_valid at T+2.
  - Last rsp at T+2+len.
  - Next accept possible at T+2+len (one IDLE arbitration cycle per burst).
- rom_addr_o holds its last value in IDLE.
- No response backpressure; clients must sink one word per cycle.
- len=0: single beat, rsp_last_o on the first response.
- A requester whose valid drops before accept is not served; a valid that rises while another burst is active waits for IDLE.
- Simultaneous valids are resolved purely by the rr pointer. No requester waits more than N_REQ-1 bursts.

Optional Feature:
- Macro ROM_BURST_ARB_STATS_EN.
- Defined:
  - Adds output grant_cnt_o, N_REQ*16 bits: one 16-bit saturating counter per requester, incremented on each accept and cleared by reset.
  - Adds output beat_cnt_o, 32 bits: wrapping count of total issued beats.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package rom_burst_arb_pkg:
  - state enum {IDLE, BURST}.
  - localparams STAT_WIDTH=16 and BEAT_CNT_WIDTH=32.
  - function for the packed-vector slice index.
- Sub-module rr_arbiter: combinational round-robin pick from valid vector and pointer, producing a one-hot grant and an index. Reused elsewhere.
- The ROM is instantiated outside, at the bench/top.

Test Plan:
- Single request, req0 addr=0x10 len=3 → accept T, rom_addr 0x10..0x13 at T+1..T+4, rsp_valid_o=0001 at T+2..T+5, rsp_last_o at T+5, data equals ROM image.
- All four requesting continuously, len=0 → grants in order 0,1,2,3,0; each rsp_valid one-hot matches owner; one grant per 2 cycles.
- Wrap: addr=0xFE len=2 → rom_addr 0xFE, 0xFF, 0x00; rsp_last_o on the 0x00 word.
- req2 valid rises mid-burst of req1 → req2 not accepted until IDLE; req2 is granted next, ahead of req0 if req0 is also valid after req1.
- Reset asserted at beat 2 of an 8-beat burst → all outputs 0 asynchronously; after release, state IDLE, rr=0, no spurious rsp_valid.
- With ROM_BURST_ARB_STATS_EN: 5 grants to req3 → grant_cnt[3]=5 and beat_cnt equals the sum of beats.

Source files
------------

// File: rtl/rom_burst_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_burst_arb_pkg
// Shared types and constants for the ROM burst arbiter.
//   state_e         : arbiter FSM state (IDLE arbitration / BURST sequencing)
//   STAT_WIDTH      : width of each per-requester grant counter (stats build)
//   BEAT_CNT_WIDTH  : width of the total issued-beat counter (stats build)
//   slice_lsb()     : LSB position of element idx in a packed per-requester bus
// -----------------------------------------------------------------------------
package rom_burst_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int STAT_WIDTH     = 16;
  localparam int BEAT_CNT_WIDTH = 32;

  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Scans the valid vector starting at ptr and
// wrapping modulo N; the first set bit wins.
// Ports:
//   valid [N-1:0]     : request vector
//   ptr   [IDX_W-1:0] : highest-priority position for this pick (< N)
//   grant [N-1:0]     : one-hot winner, zero when nothing is valid
//   idx   [IDX_W-1:0] : binary index of the winner (0 when nothing is valid)
//   any               : at least one request is valid
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int               pos;
    logic [IDX_W-1:0] sel;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    sel   = '0;
    for (int i = 0; i < N; i++) begin
      // ptr + i folded back into 0..N-1 without a divider
      pos = int'(ptr) + i;
      if (pos >= N) begin
        pos = pos - N;
      end
      sel = IDX_W'(pos);
      if (!any && valid[sel]) begin
        any = 1'b1;
        idx = sel;
      end
    end
    if (any) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// -----------------------------------------------------------------------------
// rom_burst_arbiter
// Shares one synchronous single-port ROM (1-cycle registered read) between
// N_REQ requesters. Requesters post a start address and a length (beats-1);
// the arbiter grants round-robin, walks consecutive ROM addresses for the
// burst and steers the returned words back with a one-hot valid per owner.
//
// Ports:
//   clk_i, arstn_i  : clock, asynchronous active-low reset
//   req_valid_i     : per-requester request valid
//   req_ready_o     : per-requester accept, one-hot or zero, only in IDLE
//   req_addr_i      : packed start addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   req_len_i       : packed burst lengths (beats-1)
//   rom_addr_o      : ROM address, holds its last value while idle
//   rom_data_i      : ROM registered read data
//   rsp_valid_o     : one-hot response valid (owner of the returning word)
//   rsp_data_o      : response word (ROM data passed straight through)
//   rsp_last_o      : final beat of the burst, qualified by rsp_valid_o
//   busy_o          : bursting, or a response still in flight
//
// Optional build macro ROM_BURST_ARB_STATS_EN adds:
//   grant_cnt_o     : N_REQ x 16-bit saturating accept counters
//   beat_cnt_o      : 32-bit wrapping count of issued beats
//
// Timing: accept at cycle T, addresses at T+1..T+1+len, responses at
// T+2..T+2+len, next accept possible at T+2+len.
// -----------------------------------------------------------------------------
module rom_burst_arbiter
  import rom_burst_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                        clk_i,
  input  logic                        arstn_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [N_REQ*LEN_WIDTH-1:0]  req_len_i,
  output logic [ADDR_WIDTH-1:0]       rom_addr_o,
  input  logic [DATA_WIDTH-1:0]       rom_data_i,
  output logic [N_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]       rsp_data_o,
  output logic                        rsp_last_o,
  output logic                        busy_o
`ifdef ROM_BURST_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_WIDTH-1:0] grant_cnt_o,
  output logic [BEAT_CNT_WIDTH-1:0]   beat_cnt_o
`endif
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e                 state_q;
  state_e                 state_d;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [IDX_W-1:0]       owner_q;
  logic [LEN_WIDTH-1:0]   len_q;
  logic [LEN_WIDTH-1:0]   beat_q;

  logic [N_REQ-1:0]       grant;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_any;
  logic                   accept;
  logic                   issue;
  logic                   last_beat;
  logic [ADDR_WIDTH-1:0]  start_addr;
  logic [LEN_WIDTH-1:0]   start_len;

  logic                   vld_p0;
  logic                   last_p0;
  logic [IDX_W-1:0]       owner_p0;

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
    return (cur == IDX_W'(N_REQ - 1)) ? '0 : cur + IDX_W'(1);
  endfunction

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .valid (req_valid_i),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign start_addr = req_addr_i[slice_lsb(int'(grant_idx), ADDR_WIDTH) +: ADDR_WIDTH];
  assign start_len  = req_len_i[slice_lsb(int'(grant_idx), LEN_WIDTH) +: LEN_WIDTH];

  // FSM state register
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake. Ready is also masked by arstn_i so that no
  // accept is advertised while the block is held in reset.
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    accept      = 1'b0;
    issue       = 1'b0;
    last_beat   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_any && arstn_i) begin
          req_ready_o = grant;
          accept      = 1'b1;
          state_d     = BURST;
        end
      end
      BURST: begin
        issue     = 1'b1;
        last_beat = (beat_q == len_q);
        if (last_beat) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Burst sequencing: rom_addr_o doubles as the current address, loaded on
  // accept so the first address appears on the first BURST cycle and then
  // frozen on the last beat so it holds through IDLE.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      rr_ptr_q   <= '0;
      beat_q     <= '0;
      rom_addr_o <= '0;
    end else begin
      if (accept) begin
        rr_ptr_q   <= next_ptr(grant_idx);
        beat_q     <= '0;
        rom_addr_o <= start_addr;
      end else if (issue && !last_beat) begin
        beat_q     <= beat_q + LEN_WIDTH'(1);
        rom_addr_o <= rom_addr_o + ADDR_WIDTH'(1);
      end
    end
  end

  // Burst owner and length are only consumed while a burst or its response
  // is live, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      owner_q <= grant_idx;
      len_q   <= start_len;
    end
  end

  // ---- stage p0: aligns issue tags with the ROM's one-cycle read latency ----
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= issue;
      last_p0 <= issue & last_beat;
    end
  end

  always_ff @(posedge clk_i) begin
    owner_p0 <= owner_q;
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rsp_valid_o[k] = vld_p0 && (owner_p0 == IDX_W'(k));
    end
  end

  assign rsp_last_o = vld_p0 & last_p0;
  assign rsp_data_o = rom_data_i;
  assign busy_o     = (state_q != IDLE) | vld_p0;

`ifdef ROM_BURST_ARB_STATS_EN
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == '1) ? v : v + STAT_WIDTH'(1);
  endfunction

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      grant_cnt_o <= '0;
      beat_cnt_o  <= '0;
    end else begin
      if (accept) begin
        grant_cnt_o[slice_lsb(int'(grant_idx), STAT_WIDTH) +: STAT_WIDTH] <=
          sat_inc(grant_cnt_o[slice_lsb(int'(grant_idx), STAT_WIDTH) +: STAT_WIDTH]);
      end
      if (issue) begin
        beat_cnt_o <= beat_cnt_o + BEAT_CNT_WIDTH'(1);
      end
    end
  end
`endif

endmodule
